// File: rtl/design_1_soc.sv
// Boot controller plus single-outstanding AXI4 instruction fetch engine.
// Register bus programs base/entry PC and run/hold; DEBUG shows the last fetched PC.
module design_1_soc (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        UART_RX,
    output logic        UART_TX,
    input  logic [15:0] WRADDR,
    input  logic [3:0]  BYTEEN,
    input  logic        WREN,
    input  logic [31:0] WDATA,
    input  logic [15:0] RDADDR,
    input  logic        RDEN,
    output logic [31:0] RDATA,
    output logic [31:0] DEBUG,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic [2:0]  M_AXI_ARPROT,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam logic [15:0] BOOT_BASE = 16'h1000;
    localparam logic [15:0] A_STATUS  = BOOT_BASE + 16'h0;
    localparam logic [15:0] A_CTRL    = BOOT_BASE + 16'h4;
    localparam logic [15:0] A_DRAM    = BOOT_BASE + 16'h8;
    localparam logic [15:0] A_ENTRY   = BOOT_BASE + 16'hC;
    localparam logic [15:0] A_INSTR   = BOOT_BASE + 16'h10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_run;
    logic        r_hold;
    logic [31:0] r_drambase;
    logic [31:0] r_entrypc;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_last_pc;
    logic [31:0] r_rdata;
    logic [31:0] r_araddr;

    logic        w_wr_ctrl;
    logic        w_hold_next;
    logic        w_start;
    logic        w_r_done;
    logic        w_accept;
    logic        w_load_ar;
    logic [31:0] w_fetch_pc;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    assign w_unused = ^{UART_RX, M_AXI_RRESP, M_AXI_RLAST};

    assign UART_TX       = 1'b1;
    assign M_AXI_ARLEN   = '0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARVALID = (r_state == S_AR);
    assign M_AXI_RREADY  = (r_state == S_R);
    assign M_AXI_ARADDR  = r_araddr;
    assign RDATA         = r_rdata;
    assign DEBUG         = r_last_pc;

    // START only counts when the same write leaves hold_reset cleared
    assign w_wr_ctrl   = WREN && (WRADDR == A_CTRL) && BYTEEN[0];
    assign w_hold_next = w_wr_ctrl ? WDATA[0] : r_hold;
    assign w_start     = w_wr_ctrl && WDATA[1] && !w_hold_next && !r_run;

    // A beat finishing after run was dropped is consumed but discarded
    assign w_r_done   = (r_state == S_R) && M_AXI_RVALID;
    assign w_accept   = w_r_done && r_run;
    assign w_load_ar  = (w_state_next == S_AR) && (r_state != S_AR);
    assign w_fetch_pc = (r_state == S_R) ? (r_pc + 32'd4) : r_pc;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (r_run) w_state_next = S_AR;
            S_AR:   if (M_AXI_ARREADY) w_state_next = S_R;
            S_R:    if (M_AXI_RVALID) w_state_next = r_run ? S_AR : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= S_IDLE;
            r_araddr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_ar) r_araddr <= r_drambase + w_fetch_pc;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_run      <= 1'b0;
            r_hold     <= 1'b1;
            r_drambase <= '0;
            r_entrypc  <= '0;
            r_pc       <= '0;
            r_instr    <= '0;
            r_last_pc  <= '0;
        end else begin
            if (w_wr_ctrl) r_hold <= WDATA[0];
            if (w_wr_ctrl && WDATA[0]) begin
                r_run <= 1'b0;
            end else if (w_start) begin
                r_run <= 1'b1;
            end
            if (WREN && WRADDR == A_DRAM)  r_drambase <= merge(r_drambase, WDATA, BYTEEN);
            if (WREN && WRADDR == A_ENTRY) r_entrypc  <= merge(r_entrypc, WDATA, BYTEEN);
            if (w_start) begin
                r_pc <= r_entrypc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_accept) begin
                r_last_pc <= r_pc;
                r_instr   <= M_AXI_RDATA;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (RDADDR)
            A_STATUS: w_rd_mux = {30'd0, r_hold, r_run};
            A_CTRL:   w_rd_mux = {31'd0, r_hold};
            A_DRAM:   w_rd_mux = r_drambase;
            A_ENTRY:  w_rd_mux = r_entrypc;
            A_INSTR:  w_rd_mux = r_instr;
            default:  w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rdata <= '0;
        end else if (RDEN) begin
            r_rdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_design_1_soc.sv
// Directed bench for design_1_soc: register table, fetch sequencing with an AXI
// memory responder, stalls, hold mid-beat, restart with address wrap, async reset.
module tb_design_1_soc;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        UART_RX = 1'b1;
    logic        UART_TX;
    logic [15:0] WRADDR = '0;
    logic [3:0]  BYTEEN = '0;
    logic        WREN = 1'b0;
    logic [31:0] WDATA = '0;
    logic [15:0] RDADDR = '0;
    logic        RDEN = 1'b0;
    logic [31:0] RDATA;
    logic [31:0] DEBUG;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [2:0]  ARPROT;
    logic [31:0] RDATA_M = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b1;
    logic        RVALID = 1'b0;
    logic        RREADY;

    design_1_soc dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .UART_RX(UART_RX), .UART_TX(UART_TX),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
        .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA), .DEBUG(DEBUG),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST),
        .M_AXI_ARPROT(ARPROT), .M_AXI_RDATA(RDATA_M), .M_AXI_RRESP(RRESP),
        .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- AXI memory responder ----------------
    bit          stall = 0;
    bit          rblock = 0;
    bit          pend = 0;
    bit          ar_hs = 0;
    bit          r_hs = 0;
    bit          prev_wait = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] ar_addr_s = '0;
    logic [31:0] paddr = '0;
    int unsigned ar_n = 0;
    int unsigned r_n = 0;
    int unsigned cyc = 0;
    logic [31:0] araddr_q[$];
    logic [31:0] dbg_q[$];
    int unsigned rcyc_q[$];

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            pend = 0; ar_hs = 0; r_hs = 0; prev_wait = 0;
            ARREADY = 0; RVALID = 0;
        end else begin
            cyc++;
            if (ar_hs) begin
                pend = 1; paddr = ar_addr_s; araddr_q.push_back(ar_addr_s); ar_n++;
            end
            if (r_hs) begin
                pend = 0; r_n++; rcyc_q.push_back(cyc); dbg_q.push_back(DEBUG);
            end
            if (prev_wait) begin
                chk("arvalid_held", {31'd0, ARVALID}, 32'd1);
                chk("araddr_stable", ARADDR, prev_addr);
            end
            ARREADY = ARVALID && !pend && (!stall || $urandom_range(0, 2) == 0);
            RVALID  = pend && !rblock && (!stall || $urandom_range(0, 2) == 0);
            RDATA_M = memword(paddr);
            RRESP   = stall ? 2'($urandom_range(0, 3)) : 2'b00;
            ar_hs     = ARVALID && ARREADY;
            ar_addr_s = ARADDR;
            prev_wait = ARVALID && !ARREADY;
            prev_addr = ARADDR;
            r_hs      = RVALID && RREADY;
        end
    end

    // ---------------- register bus helpers ----------------
    task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge ACLK);
        WREN = 1; WRADDR = a; BYTEEN = be; WDATA = d;
        @(negedge ACLK);
        WREN = 0; BYTEEN = '0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge ACLK);
        RDEN = 1; RDADDR = a;
        @(negedge ACLK);
        RDEN = 0;
        d = RDATA;
    endtask

    task automatic wait_rn(input int unsigned n, input string nm);
        int unsigned t = 0;
        while (r_n < n && t < 3000) begin @(posedge ACLK); t++; end
        if (r_n < n) begin
            checks++; errors++;
            $display("FAIL timeout_%s: r_n=%0d expected >=%0d", nm, r_n, n);
        end
    endtask

    task automatic wait_arn(input int unsigned n, input string nm);
        int unsigned t = 0;
        while (ar_n < n && t < 3000) begin @(posedge ACLK); t++; end
        if (ar_n < n) begin
            checks++; errors++;
            $display("FAIL timeout_%s: ar_n=%0d expected >=%0d", nm, ar_n, n);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(bit w, logic [15:0] a, logic [3:0] be,
                                 logic [31:0] d, logic [31:0] e, string nm);
        vec_t v;
        v.is_wr = w; v.addr = a; v.be = be; v.data = d; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] rv;
        int unsigned base_ar, base_r, saved_ar, acc;

        addv(0, 16'h1000, 4'h0, 0, 32'h2, "status_rst");
        addv(0, 16'h1004, 4'h0, 0, 32'h1, "ctrl_rst");
        addv(0, 16'h1008, 4'h0, 0, 32'h0, "dram_rst");
        addv(0, 16'h100C, 4'h0, 0, 32'h0, "entry_rst");
        addv(0, 16'h1010, 4'h0, 0, 32'h0, "instr_rst");
        addv(1, 16'h1008, 4'hF, 32'h2000_0000, 0, "");
        addv(0, 16'h1008, 4'h0, 0, 32'h2000_0000, "dram_rw");
        addv(1, 16'h100C, 4'h2, 32'hAABB_CCDD, 0, "");
        addv(0, 16'h100C, 4'h0, 0, 32'h0000_CC00, "entry_be2");
        addv(1, 16'h100C, 4'hF, 32'h0, 0, "");
        addv(0, 16'h100C, 4'h0, 0, 32'h0, "entry_zero");
        addv(1, 16'h1014, 4'hF, 32'hFFFF_FFFF, 0, "");
        addv(0, 16'h1014, 4'h0, 0, 32'h0, "unmapped_rd");
        addv(0, 16'h1002, 4'h0, 0, 32'h0, "unaligned_rd");
        addv(1, 16'h1000, 4'hF, 32'hFFFF_FFFF, 0, "");
        addv(0, 16'h1000, 4'h0, 0, 32'h2, "status_ro");
        addv(1, 16'h1004, 4'h2, 32'h0000_0002, 0, "");
        addv(0, 16'h1000, 4'h0, 0, 32'h2, "start_nobyte0");
        addv(1, 16'h1004, 4'h1, 32'h0000_0003, 0, "");
        addv(0, 16'h1000, 4'h0, 0, 32'h2, "start_with_hold");
        addv(0, 16'h1004, 4'h0, 0, 32'h1, "ctrl_start_reads0");
        addv(1, 16'h1004, 4'h1, 32'h0000_0000, 0, "");
        addv(0, 16'h1000, 4'h0, 0, 32'h0, "hold_cleared");
        addv(1, 16'h1004, 4'h1, 32'h0000_0001, 0, "");
        addv(0, 16'h1004, 4'h0, 0, 32'h1, "hold_set");

        // reset
        repeat (3) @(negedge ACLK);
        chk("rst_rdata", RDATA, 0);
        chk("rst_debug", DEBUG, 0);
        chk("rst_arvalid", {31'd0, ARVALID}, 0);
        chk("rst_rready", {31'd0, RREADY}, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("uart_tx", {31'd0, UART_TX}, 1);
        chk("arsize", {29'd0, ARSIZE}, 32'd2);
        chk("arburst_len", {22'd0, ARBURST, ARLEN}, 32'h100);
        ARESETN = 1;

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].addr, tbl[i].be, tbl[i].data);
            end else begin
                rd(tbl[i].addr, rv);
                chk(tbl[i].name, rv, tbl[i].exp);
            end
        end

        // same-cycle read and write returns the old value
        @(negedge ACLK);
        WREN = 1; WRADDR = 16'h1008; BYTEEN = 4'hF; WDATA = 32'h1234_5678;
        RDEN = 1; RDADDR = 16'h1008;
        @(negedge ACLK);
        WREN = 0; RDEN = 0; BYTEEN = '0;
        chk("rw_same_cycle_old", RDATA, 32'h2000_0000);
        rd(16'h1008, rv);
        chk("rw_same_cycle_new", rv, 32'h1234_5678);
        wr(16'h1008, 4'hF, 32'h2000_0000);

        // start: ARVALID rises one edge after the START edge
        wr(16'h1004, 4'h1, 32'h2);
        chk("arvalid_not_yet", {31'd0, ARVALID}, 0);
        @(posedge ACLK); #1;
        chk("arvalid_rise", {31'd0, ARVALID}, 1);
        chk("first_araddr", ARADDR, 32'h2000_0000);
        rd(16'h1000, rv);
        chk("status_run", rv, 32'h1);

        wait_rn(10, "fetch10");
        stall = 1;
        wait_rn(24, "fetch_stall");

        // hold while a beat is outstanding in R
        rblock = 1;
        begin
            int unsigned t = 0;
            do begin @(posedge ACLK); t++; end while (!pend && t < 3000);
            if (!pend) begin
                checks++; errors++;
                $display("FAIL timeout_pend: pend=0 expected 1");
            end
        end
        wr(16'h1004, 4'h1, 32'h1);
        rblock = 0;
        wait_rn(ar_n, "drain");
        saved_ar = ar_n;
        repeat (6) @(negedge ACLK);
        chk("no_new_ar", ar_n, saved_ar);
        chk("arvalid_idle", {31'd0, ARVALID}, 0);
        acc = r_n - 1;
        chk("debug_after_hold", DEBUG, 4 * (acc - 1));
        chk("debug_discard", dbg_q[r_n - 1], 4 * (acc - 1));
        rd(16'h1000, rv);
        chk("status_hold", rv, 32'h2);
        rd(16'h1010, rv);
        chk("instr_last", rv, memword(32'h2000_0000 + 4 * (acc - 1)));
        for (int i = 0; i < int'(ar_n); i++)
            chk($sformatf("araddr_%0d", i), araddr_q[i], 32'h2000_0000 + 4 * i);
        for (int i = 0; i < int'(acc); i++)
            chk($sformatf("debug_%0d", i), dbg_q[i], 4 * i);
        chk("fetch_period", rcyc_q[5] - rcyc_q[4], 2);

        // restart with wrap, then START while running must not reload pc
        stall = 0;
        base_ar = ar_n;
        base_r  = r_n;
        wr(16'h100C, 4'hF, 32'h0000_0100);
        wr(16'h1008, 4'hF, 32'hFFFF_FF00);
        wr(16'h1004, 4'h1, 32'h2);
        wait_arn(base_ar + 3, "restart");
        wr(16'h1004, 4'h1, 32'h2);
        rd(16'h1000, rv);
        chk("status_rerun", rv, 32'h1);
        wait_rn(base_r + 10, "rerun");
        chk("wrap_araddr", araddr_q[base_ar], 32'h0);
        for (int i = int'(base_ar); i < int'(ar_n); i++)
            chk($sformatf("rerun_araddr_%0d", i), araddr_q[i], 4 * (i - int'(base_ar)));
        for (int i = int'(base_r); i < int'(r_n); i++)
            chk($sformatf("rerun_debug_%0d", i), dbg_q[i], 32'h100 + 4 * (i - int'(base_r)));

        // asynchronous reset between edges
        @(posedge ACLK); #3;
        ARESETN = 0;
        #1;
        chk("arst_arvalid", {31'd0, ARVALID}, 0);
        chk("arst_rready", {31'd0, RREADY}, 0);
        chk("arst_debug", DEBUG, 0);
        chk("arst_rdata", RDATA, 0);
        chk("arst_araddr", ARADDR, 0);
        repeat (2) @(negedge ACLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/design_1_soc.md
# design_1_soc

Boot-controlled instruction-fetch subsystem for the ChiffonCore FPGA build. A 16-bit register bus programs a boot controller with a DRAM base, an entry PC and run/hold control. Once started, a fetch engine issues sequential single-beat AXI4 reads to external memory and exposes the PC of the last completed fetch on `DEBUG`. The UART pins are reserved, with TX idle.

## Interface
- No parameters. Register base `BOOT_BASE` = 0x1000 (fixed).
- `ACLK` in 1: single clock; all logic on rising edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `UART_RX` in 1: reserved, ignored.
- `UART_TX` out 1: constant 1 (idle).
- `WRADDR` in 16: register write address.
- `BYTEEN` in 4: write byte enables; bit n enables `WDATA[8n+7:8n]`.
- `WREN` in 1: write strobe, sampled on posedge.
- `WDATA` in 32: write data.
- `RDADDR` in 16: register read address.
- `RDEN` in 1: read strobe, sampled on posedge.
- `RDATA` out 32: registered read data.
- `DEBUG` out 32: `last_pc`.
- `M_AXI_ARADDR` out 32, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1, `M_AXI_ARLEN` out 8 (0), `M_AXI_ARSIZE` out 3 (3'b010), `M_AXI_ARBURST` out 2 (2'b01), `M_AXI_ARPROT` out 3 (0).
- `M_AXI_RDATA` in 32, `M_AXI_RRESP` in 2, `M_AXI_RLAST` in 1, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1.

## Operation
- **Registers:** 32-bit, word addressed; unmapped addresses read 0 and ignore writes.
  - 0x1000 STATUS (RO): bit0 = run, bit1 = hold_reset.
  - 0x1004 CTRL: bit0 HOLD_RESET (level, R/W); bit1 START (write-1-pulse, reads 0).
  - 0x1008 DRAMBASE (R/W).
  - 0x100C ENTRYPC (R/W).
  - 0x1010 INSTR (RO): last fetched word.
- **Byte enables:** every write merges only the enabled bytes.
- **START:** a CTRL write with byte0 enabled, `WDATA[1]`=1 and resulting hold_reset=0, while run=0, sets run=1 and pc=ENTRYPC. START while run=1 is ignored. START with resulting hold_reset=1 is ignored.
- **HOLD_RESET=1:** clears run. The fetch engine returns to IDLE after any transaction already in flight completes. That beat is discarded: no `last_pc` or INSTR update. pc stays unchanged.
- **Fetch FSM:**
  - IDLE → AR when run=1.
  - AR: `ARVALID`=1 with `ARADDR` = DRAMBASE + pc (mod 2^32), held stable until `ARREADY`; then → R.
  - R: `RREADY`=1; on `RVALID`: `last_pc`←pc, INSTR←`RDATA`, pc←pc+4 (mod 2^32); then → AR if run=1, else IDLE.
- **Outstanding reads:** one at a time. `RRESP` and `RLAST` are ignored, and an error response still advances.
- **Fetch-only:** no instructions are executed.

## Timing
- **Reset values:**
  - `RDATA`=0, `DEBUG`=0, `ARVALID`=0, `RREADY`=0, `ARADDR`=0.
  - run=0, hold_reset=1, DRAMBASE=0, ENTRYPC=0, pc=0, INSTR=0, FSM=IDLE.
- **Write latency:** a register write takes effect at the posedge where `WREN`=1. The START write's posedge sets run; `ARVALID` rises on the following posedge.
- **Read latency:** `RDATA` loads at the posedge where `RDEN`=1 and holds otherwise. Data is valid one cycle after the strobe edge.
- **Same-cycle read and write** to one address: the read returns the old value.
- **`ARVALID`** is never deasserted before `ARREADY`, including when HOLD_RESET is written mid-transfer.
- **`last_pc`** updates on the `RVALID` handshake edge.
- **Minimum fetch period:** 2 cycles per word when `ARREADY` and `RVALID` are immediate.
- **Asynchronous reset** mid-transaction returns everything to reset values immediately.

## Test plan
- **Reset / readback:** reset, read 0x1000 → 0x2; read 0x1004 → 0x1; `DEBUG`=0; `UART_TX`=1.
- **Register access:** write DRAMBASE=0x2000_0000 and ENTRYPC=0; read back exact values. Write with `BYTEEN`=4'h2 and `WDATA`=0xAABBCCDD → only byte1 changes. Unmapped read → 0.
- **Start and fetch:** with memory at 0x2000_0000, write CTRL `BYTEEN`=1, `WDATA`=0x2. STATUS → 0x1. `ARADDR` sequence is 0x2000_0000, 0x2000_0004, …. `DEBUG` steps 0, 4, 8, … 0x24 over 10 fetches. INSTR matches memory words.
- **Random `ARREADY` / `RVALID` stalls:** `ARADDR` stays stable while `ARVALID` waits; `DEBUG` sequence unchanged.
- **Hold mid-transaction:** write CTRL=0x1 during the R state. The beat completes, `DEBUG` does not update, no new `ARVALID`, STATUS → 0x2.
- **START while running:** START with ENTRYPC=0x100 → pc not reloaded. Restarting after hold (ENTRYPC=0x100, DRAMBASE=0xFFFF_FF00) → `ARADDR` wraps to 0x0000_0000.
